// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the mux select arbiter
//
// Purpose: channel count, the mux select code type shared with the mux-side
// integration, the arbiter state encoding and a one-hot decode helper.
// Ports: none (package).

package mux_arb_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // One-hot decode of a select code, used for in_ready and for masking the
  // channel that just hit its burst limit.
  function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t s);
    logic [NUM_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker
//
// Purpose: returns the first set bit of req, scanning ptr, ptr+1, ... mod 4.
// Ports:
//   req  in  4 : request vector
//   ptr  in  2 : index at which the scan starts
//   idx  out 2 : selected index (equals ptr when req is zero)
//   any  out 1 : req has at least one bit set

module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output sel_t              idx,
  output logic              any
);

  // Scan from the farthest offset down to offset 0 so the nearest requester
  // to ptr is the last assignment and wins. The 2-bit sum wraps mod 4.
  always_comb begin
    sel_t cand;
    cand = ptr;
    idx  = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - 4-channel round-robin arbiter driving the 4:1 mux select
//
// Purpose: grants one channel at a time to a single downstream consumer,
// holding the grant for up to MAX_BURST consecutive transfers, and owns the
// registered mux select code.
// Ports:
//   clk        in  1 : rising-edge clock
//   rst_n      in  1 : asynchronous active-low reset
//   in_valid   in  4 : per-channel request (bit 0 = mux in_a ... bit 3 = in_d)
//   out_ready  in  1 : downstream accepts the current transfer
//   sel        out 2 : registered mux select code
//   out_valid  out 1 : selected channel's data is valid
//   in_ready   out 4 : one-hot ready to the granted channel
//   busy       out 1 : a grant is held

module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic              out_ready,
  output sel_t              sel,
  output logic              out_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic              busy
);

  localparam int unsigned   BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

  arb_state_t    state_q;
  sel_t          sel_q;
  sel_t          ptr_q;
  logic [BW-1:0] bcnt_q;

  sel_t          ptr_d;
  logic [BW-1:0] bcnt_d;

  logic              granted;
  logic              cur_valid;
  logic              hs;
  logic              limit_hit;
  logic              end_of_grant;
  logic [NUM_CH-1:0] eog_req;
  sel_t              idle_idx;
  sel_t              eog_idx;
  logic              idle_any;
  logic              eog_any;

  assign granted      = (state_q == GRANT);
  assign cur_valid    = in_valid[sel_q];
  assign hs           = granted & cur_valid & out_ready;
  assign limit_hit    = hs & (bcnt_q == BCNT_LAST);
  assign end_of_grant = granted & (limit_hit | ~cur_valid);

  // The channel that just used its full burst is masked so a waiting peer
  // wins; a lone requester comes back one cycle later through IDLE.
  assign eog_req = limit_hit ? (in_valid & ~sel_onehot(sel_q)) : in_valid;

  assign ptr_d  = sel_q + sel_t'(1);
  assign bcnt_d = bcnt_q + BW'(1);

  rr_pick4 u_pick_idle (
    .req (in_valid),
    .ptr (ptr_q),
    .idx (idle_idx),
    .any (idle_any)
  );

  rr_pick4 u_pick_eog (
    .req (eog_req),
    .ptr (ptr_d),
    .idx (eog_idx),
    .any (eog_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_any) begin
            sel_q   <= idle_idx;
            bcnt_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (end_of_grant) begin
            ptr_q <= ptr_d;
            if (eog_any) begin
              // Back-to-back hand-off, no bubble cycle.
              sel_q  <= eog_idx;
              bcnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (hs) begin
            bcnt_q <= bcnt_d;
          end
        end
      endcase
    end
  end

  // Decoded from state and inputs only; out_ready never reaches out_valid.
  assign sel       = sel_q;
  assign busy      = granted;
  assign out_valid = granted & cur_valid;
  assign in_ready  = granted ? (sel_onehot(sel_q) & {NUM_CH{out_ready}}) : '0;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - self-checking bench for mux_sel_arbiter
//
// Three arbiters with MAX_BURST = 1, 2 and 4 share one stimulus stream and
// are each compared against a transaction-level reference model.

module tb_mux_sel_arbiter;

  localparam int NI = 3;
  localparam int BURST [NI] = '{1, 2, 4};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in_valid = 4'b0000;
  logic       out_ready = 1'b0;

  logic [1:0] sel_w  [NI];
  logic       ov_w   [NI];
  logic [3:0] ir_w   [NI];
  logic       busy_w [NI];

  int checks = 0;
  int errors = 0;

  // Reference model: whether a grant is held, who holds it, how many
  // transfers it has made and where the next fresh arbitration starts.
  bit m_grant [NI];
  int m_sel   [NI];
  int m_cnt   [NI];
  int m_ptr   [NI];

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .sel(sel_w[0]), .out_valid(ov_w[0]), .in_ready(ir_w[0]), .busy(busy_w[0]));

  mux_sel_arbiter #(.MAX_BURST(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .sel(sel_w[1]), .out_valid(ov_w[1]), .in_ready(ir_w[1]), .busy(busy_w[1]));

  mux_sel_arbiter #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .sel(sel_w[2]), .out_valid(ov_w[2]), .in_ready(ir_w[2]), .busy(busy_w[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int p);
    for (int k = 0; k < 4; k++) begin
      if (req[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      m_grant[m] = 1'b0;
      m_sel[m]   = 0;
      m_cnt[m]   = 0;
      m_ptr[m]   = 0;
    end
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step(input logic [3:0] iv, input logic rdy);
    for (int m = 0; m < NI; m++) begin
      int c;
      if (!m_grant[m]) begin
        c = pick(iv, m_ptr[m]);
        if (c >= 0) begin
          m_grant[m] = 1'b1;
          m_sel[m]   = c;
          m_cnt[m]   = 0;
        end
      end else begin
        bit v, xfer, full;
        logic [3:0] req;
        v    = iv[m_sel[m]];
        xfer = v && rdy;
        full = xfer && (m_cnt[m] + 1 == BURST[m]);
        if (full || !v) begin
          req = iv;
          if (full) req[m_sel[m]] = 1'b0;
          m_ptr[m] = (m_sel[m] + 1) % 4;
          c = pick(req, m_ptr[m]);
          if (c >= 0) begin
            m_sel[m] = c;
            m_cnt[m] = 0;
          end else begin
            m_grant[m] = 1'b0;
          end
        end else if (xfer) begin
          m_cnt[m]++;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int m = 0; m < NI; m++) begin
      logic [3:0] exp_ir;
      exp_ir = 4'b0000;
      if (m_grant[m] && out_ready) exp_ir[m_sel[m]] = 1'b1;
      chk($sformatf("sel[B=%0d]", BURST[m]), 8'(sel_w[m]), 8'(m_sel[m]));
      chk($sformatf("out_valid[B=%0d]", BURST[m]), 8'(ov_w[m]),
          8'(m_grant[m] && in_valid[m_sel[m]]));
      chk($sformatf("in_ready[B=%0d]", BURST[m]), 8'(ir_w[m]), 8'(exp_ir));
      chk($sformatf("busy[B=%0d]", BURST[m]), 8'(busy_w[m]), 8'(m_grant[m]));
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [3:0] iv, input logic rdy);
    in_valid  = iv;
    out_ready = rdy;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(in_valid, out_ready);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < NI; m++) begin
      chk({tag, "_out_valid"}, 8'(ov_w[m]), 8'h00);
      chk({tag, "_in_ready"}, 8'(ir_w[m]), 8'h00);
      chk({tag, "_busy"}, 8'(busy_w[m]), 8'h00);
      chk({tag, "_sel"}, 8'(sel_w[m]), 8'h00);
    end
  endtask

  // Reset is asserted between clock edges; outputs must drop with no edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] hist;
    logic [3:0] iv;

    model_reset();
    #1;
    do_reset("reset");

    // Lone channel 2, MAX_BURST=4: 4 transfers, one idle cycle, re-grant.
    hist = '0;
    for (int i = 0; i < 7; i++) begin
      drive(4'b0100, 1'b1);
      hist[i] = ir_w[2][2];
      if (i == 1) begin
        chk("single_sel", 8'(sel_w[2]), 8'd2);
        chk("single_out_valid", 8'(ov_w[2]), 8'd1);
        chk("single_in_ready", 8'(ir_w[2]), 8'b0100);
      end
      tick();
    end
    chk("single_burst_pattern", 8'(hist), 8'b0101_1110);

    // All four requesting, MAX_BURST=2: 0,0,1,1,2,2,3,3,0 with no bubbles.
    do_reset("reset_rr");
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 1'b1);
      if (i > 0) begin
        chk("rr_seq_sel", 8'(sel_w[1]), 8'(((i - 1) / 2) % 4));
        chk("rr_onehot_ready", 8'($countones(ir_w[1])), 8'd1);
      end
      tick();
    end

    // Backpressure on channel 1: everything holds, then transfers resume.
    do_reset("reset_bp");
    drive(4'b0010, 1'b1); tick();
    drive(4'b0010, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 1'b0);
      chk("bp_sel", 8'(sel_w[2]), 8'd1);
      chk("bp_out_valid", 8'(ov_w[2]), 8'd1);
      chk("bp_in_ready", 8'(ir_w[2]), 8'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 1'b1); tick();
    end

    // Channel 3 withdraws after one transfer while channel 0 waits.
    do_reset("reset_wd");
    drive(4'b1000, 1'b1); tick();
    drive(4'b1001, 1'b1);
    chk("wd_sel3", 8'(sel_w[2]), 8'd3);
    tick();
    drive(4'b0001, 1'b1); tick();
    drive(4'b0001, 1'b1);
    chk("wd_sel0", 8'(sel_w[2]), 8'd0);
    chk("wd_out_valid", 8'(ov_w[2]), 8'd1);
    tick();

    // MAX_BURST=1 fairness: a one-cycle pulse from channel 2 wins next.
    do_reset("reset_fair");
    drive(4'b0001, 1'b1); tick();
    drive(4'b0101, 1'b1);
    chk("fair_sel0", 8'(sel_w[0]), 8'd0);
    tick();
    drive(4'b0001, 1'b1);
    chk("fair_sel2", 8'(sel_w[0]), 8'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b1); tick();
    end

    // Async reset mid-burst on channel 1 with two transfers done.
    do_reset("reset_pre_async");
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b1); tick();
    end
    drive(4'b0010, 1'b1);
    chk("async_pre_out_valid", 8'(ov_w[2]), 8'd1);
    #2;
    do_reset("async_mid_burst");
    drive(4'b1010, 1'b1); tick();
    drive(4'b1010, 1'b1);
    chk("async_regrant_sel", 8'(sel_w[2]), 8'd1);
    tick();

    // Randomized traffic with sticky requests and random backpressure.
    iv = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) iv[b] = ~iv[b];
      end
      drive(iv, ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
